fp16_operand_sequencer: RTL and testbench
=========================================

FP16_OPERAND_SEQUENCER -- requirements
Module: fp16_operand_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of clock cycles the adder result is allowed to settle before capture; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset; asynchronous, active-low.
REQ-004 SHALL have port data_in, input, 16, the FP16 operand bus; first word is operand A, second word is operand B.
REQ-005 SHALL have port data_valid, input, 1, meaning data_in holds an operand.
REQ-006 SHALL have port data_ready, output, 1, meaning the block accepts an operand this cycle.
REQ-007 SHALL have port sum_a, output, 16, the registered operand A driven to the adder.
REQ-008 SHALL have port sum_b, output, 16, the registered operand B driven to the adder.
REQ-009 SHALL have port sum_result, input, 16, the combinational adder result.
REQ-010 SHALL have port out_data, output, 16, the final result.
REQ-011 SHALL have port out_flags, output, 4, the status flags {sign_err, special, zero_bypass, overflow} in bits [3:0].
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the result handshake.

Function
REQ-013 SHALL implement the FSM LOAD_A -> LOAD_B -> SETTLE -> HOLD -> LOAD_A.
REQ-014 SHALL assert data_ready=1 only in LOAD_A and LOAD_B.
REQ-015 SHALL treat a transfer (data_valid & data_ready) in LOAD_A as loading sum_a and moving to LOAD_B; in LOAD_B, SHALL load sum_b, clear the settle counter and move to SETTLE.
REQ-016 SHALL hold sum_a and sum_b stable from their load until the output handshake completes.
REQ-017 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles; at its last edge it SHALL register out_data/out_flags and enter HOLD. With default 1: B accepted at edge k gives out_valid=1 after edge k+1.
REQ-018 SHALL set out_valid=1 only in HOLD; out_data and out_flags SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 SHALL return to LOAD_A on out_valid & out_ready; no new operand is accepted in that same cycle.
REQ-020 SHALL select the result with priority: (a) either sign bit set -> 16'h7E00, sign_err; (b) either exponent == 31 -> 16'h7E00 if any such operand has a nonzero mantissa, else 16'h7C00, special; (c) exactly one exponent == 0 -> the other operand, zero_bypass; both zero -> 16'h0000, zero_bypass; (d) sum_result[14:10] == 31 -> 16'h7C00, overflow; (e) otherwise sum_result with sign 0, flags 0.
REQ-021 SHALL raise exactly one flag per result; out_data[15] SHALL be 0 except for NaN results.
REQ-022 SHALL ignore data_in and data_valid in SETTLE and HOLD.

Reset
REQ-023 SHALL, on reset_n=0, immediately force: state LOAD_A, sum_a=sum_b=0, out_data=0, out_flags=0, out_valid=0, settle counter 0.
REQ-024 SHALL drive data_ready=1 from the first edge after reset_n deasserts.
REQ-025 SHALL discard an in-flight operation on reset mid-operation; no stale result may appear after reset.

Structure
REQ-026 SHALL take the following from shared package fp16_calc_pkg: the state enum, flag bit indices, and constants FP16_QNAN=16'h7E00, FP16_PINF=16'h7C00 and EXP_MAX=5'd31.
REQ-027 SHALL place operand classification (sign, zero, inf, nan) in one combinational sub-module, fp16_classify, instantiated once per operand.
REQ-028 SHALL be connected to the real adder in the bench: sum_a/sum_b drive the adder inputs and the adder result returns on sum_result.

Verification
REQ-029 SHALL cover: A=3C00, B=3C00 -> out_data=4000, flags=0000, out_valid 2 cycles after the B transfer.
REQ-030 SHALL cover: A=0000, B=3C00 -> 3C00, zero_bypass; A=0000, B=0000 -> 0000, zero_bypass.
REQ-031 SHALL cover: A=7C00, B=3C00 -> 7C00, special; A=7C01, B=3C00 -> 7E00, special; A=BC00, B=3C00 -> 7E00, sign_err.
REQ-032 SHALL cover: A=7BFF, B=7BFF -> 7C00, overflow.
REQ-033 SHALL cover: out_ready held low 5 cycles in HOLD -> out_data/out_flags constant and data_ready=0 throughout; a data_valid pulse meanwhile is ignored.
REQ-034 SHALL cover: reset_n pulsed during SETTLE -> out_valid=0, then the next pair 4000+4000 -> 4400 with no stale result.

Source files
------------

// File: rtl/fp16_calc_pkg.sv
// fp16_calc_pkg: shared FSM states, status flag positions and FP16 constants
package fp16_calc_pkg;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, SETTLE, HOLD} state_e;
  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic nan;
  } fp16_class_t;
  localparam int FLAG_OVF     = 0;
  localparam int FLAG_ZB      = 1;
  localparam int FLAG_SPECIAL = 2;
  localparam int FLAG_SIGN    = 3;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [4:0]  EXP_MAX   = 5'd31;
endpackage

// File: rtl/fp16_classify.sv
// fp16_classify: combinational sign/zero/inf/nan classification of one FP16 word
module fp16_classify
  import fp16_calc_pkg::*;
(
  input  logic [15:0]  op_i,
  output fp16_class_t  cls_o
);
  assign cls_o = '{
    sign: op_i[15],
    zero: op_i[14:10] == 5'd0,
    inf:  op_i[14:10] == EXP_MAX && op_i[9:0] == 10'd0,
    nan:  op_i[14:10] == EXP_MAX && op_i[9:0] != 10'd0
  };
endmodule

// File: rtl/fp16_operand_sequencer.sv
// fp16_operand_sequencer: loads two FP16 operands, lets an external adder settle,
// then presents a screened result with one status flag over a valid/ready handshake
module fp16_operand_sequencer
  import fp16_calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [15:0] sum_a,
  output logic [15:0] sum_b,
  input  logic [15:0] sum_result,
  output logic [15:0] out_data,
  output logic [3:0]  out_flags,
  output logic        out_valid,
  input  logic        out_ready
);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]  flags_q, flags_d;
  logic        rdy_q;
  logic        xfer, settle_last;
  logic [15:0] res;
  logic [3:0]  res_flags;
  fp16_class_t ca, cb;

  fp16_classify u_cls_a (.op_i(a_q), .cls_o(ca));
  fp16_classify u_cls_b (.op_i(b_q), .cls_o(cb));

  assign data_ready  = rdy_q && (state_q == LOAD_A || state_q == LOAD_B);
  assign xfer        = data_valid && data_ready;
  assign settle_last = cnt_q == 4'(SETTLE_CYCLES - 1);
  assign out_valid   = state_q == HOLD;
  assign sum_a       = a_q;
  assign sum_b       = b_q;
  assign out_data    = data_q;
  assign out_flags   = flags_q;

  // Priority screen: sign, then inf/nan, then zero bypass, then adder overflow
  always_comb begin
    res       = sum_result & 16'h7FFF;
    res_flags = '0;
    if (ca.sign || cb.sign) begin
      res                  = FP16_QNAN;
      res_flags[FLAG_SIGN] = 1'b1;
    end else if (ca.inf || ca.nan || cb.inf || cb.nan) begin
      res                     = (ca.nan || cb.nan) ? FP16_QNAN : FP16_PINF;
      res_flags[FLAG_SPECIAL] = 1'b1;
    end else if (ca.zero || cb.zero) begin
      res                = ca.zero ? (cb.zero ? 16'h0000 : b_q) : a_q;
      res_flags[FLAG_ZB] = 1'b1;
    end else if (sum_result[14:10] == EXP_MAX) begin
      res                 = FP16_PINF;
      res_flags[FLAG_OVF] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    flags_d = flags_q;
    case (state_q)
      LOAD_A: if (xfer) begin
        a_d     = data_in;
        state_d = LOAD_B;
      end
      LOAD_B: if (xfer) begin
        b_d     = data_in;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: if (settle_last) begin
        data_d  = res;
        flags_d = res_flags;
        state_d = HOLD;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      HOLD:    state_d = out_ready ? LOAD_A : HOLD;
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      flags_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      rdy_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fp16_operand_sequencer.sv
// tb_fp16_operand_sequencer: directed and random operand pairs against a behavioural
// adder plus a result-screening reference model
module tb_fp16_operand_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [15:0] sum_a, sum_b, sum_result, out_data;
  logic [3:0]  out_flags;
  logic        out_valid;
  logic        out_ready = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp16_operand_sequencer dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .sum_a(sum_a), .sum_b(sum_b), .sum_result(sum_result),
    .out_data(out_data), .out_flags(out_flags), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Round-to-nearest-even adder for positive normal operands; overflow gives +inf
  function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b;
    longint ma, mb, s, m;
    int e, d;
    logic sticky, rnd;
    a = x; b = y;
    if (y[14:10] > x[14:10]) begin a = y; b = x; end
    e  = int'(a[14:10]);
    d  = e - int'(b[14:10]);
    if (d > 30) d = 30;
    ma = longint'({1'b1, a[9:0]}) << 13;
    mb = longint'({1'b1, b[9:0]}) << 13;
    sticky = ((mb >> d) << d) != mb;
    s = ma + (mb >> d);
    if (s >= (64'sd1 << 24)) begin sticky = sticky | s[0]; s = s >> 1; e++; end
    rnd = s[12] && (sticky || s[11:0] != 12'd0 || s[13]);
    m = (s >> 13) + longint'(rnd);
    if (m == 2048) begin m = 1024; e++; end
    return (e >= 31) ? 16'h7C00 : {1'b0, 5'(e), m[9:0]};
  endfunction

  assign sum_result = fadd(sum_a, sum_b);

  // Returns {flags[3:0], data[15:0]} with flags = {sign_err, special, zero_bypass, overflow}
  function automatic logic [19:0] ref_model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    bit a_inf_nan, b_inf_nan, any_nan;
    s = fadd(a, b);
    a_inf_nan = a[14:10] == 5'd31;
    b_inf_nan = b[14:10] == 5'd31;
    any_nan = (a_inf_nan && a[9:0] != 0) || (b_inf_nan && b[9:0] != 0);
    if (a[15] || b[15]) return {4'b1000, 16'h7E00};
    if (a_inf_nan || b_inf_nan) return {4'b0100, any_nan ? 16'h7E00 : 16'h7C00};
    if (a[14:10] == 0 && b[14:10] == 0) return {4'b0010, 16'h0000};
    if (a[14:10] == 0) return {4'b0010, b};
    if (b[14:10] == 0) return {4'b0010, a};
    if (s[14:10] == 5'd31) return {4'b0001, 16'h7C00};
    return {4'b0000, 1'b0, s[14:0]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [19:0] e;
    int n;
    e = ref_model(a, b);
    n = 0;
    @(negedge clk);
    while (!data_ready && n < 20) begin n++; @(negedge clk); end
    chk("ready_a", 16'(data_ready), 16'd1);
    data_in = a; data_valid = 1'b1;
    @(negedge clk);
    chk("ready_b", 16'(data_ready), 16'd1);
    data_in = b;
    @(negedge clk);
    data_valid = 1'b0; data_in = 16'hDEAD;
    chk("settle_valid", 16'(out_valid), 16'd0);
    chk("settle_ready", 16'(data_ready), 16'd0);
    @(negedge clk);
    chk("valid", 16'(out_valid), 16'd1);
    chk("data", out_data, e[15:0]);
    chk("flags", 16'(out_flags), 16'(e[19:16]));
    chk("sum_a", sum_a, a);
    chk("sum_b", sum_b, b);
    for (int i = 0; i < hold; i++) begin
      data_valid = (i == 1); data_in = 16'h1234;
      @(negedge clk);
      chk("hold_valid", 16'(out_valid), 16'd1);
      chk("hold_data", out_data, e[15:0]);
      chk("hold_flags", 16'(out_flags), 16'(e[19:16]));
      chk("hold_ready", 16'(data_ready), 16'd0);
      chk("hold_sum_a", sum_a, a);
    end
    data_valid = 1'b1; data_in = ~a; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; data_valid = 1'b0;
    chk("done_valid", 16'(out_valid), 16'd0);
    chk("done_ready", 16'(data_ready), 16'd1);
    chk("done_sum_a", sum_a, a);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0:       return {1'b0, 5'd0, r[9:0]};
      1:       return {1'b0, 5'd31, (r[0] ? r[9:0] : 10'd0)};
      2:       return {1'b1, r[14:0]};
      3:       return {1'b0, 5'(28 + $urandom_range(0, 2)), r[9:0]};
      default: return {1'b0, 5'($urandom_range(1, 30)), r[9:0]};
    endcase
  endfunction

  initial begin
    #1;
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_flags", 16'(out_flags), 16'd0);
    chk("rst_sum_a", sum_a, 16'h0000);
    chk("rst_sum_b", sum_b, 16'h0000);
    chk("rst_ready", 16'(data_ready), 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 16'(data_ready), 16'd1);

    run_pair(16'h3C00, 16'h3C00, 5);
    run_pair(16'h0000, 16'h3C00, 0);
    run_pair(16'h0000, 16'h0000, 1);
    run_pair(16'h7C00, 16'h3C00, 0);
    run_pair(16'h7C01, 16'h3C00, 2);
    run_pair(16'hBC00, 16'h3C00, 0);
    run_pair(16'h7BFF, 16'h7BFF, 0);
    run_pair(16'h3C00, 16'h0001, 0);

    // Abort an operation while the adder is settling
    @(negedge clk);
    data_in = 16'h4000; data_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 16'(out_valid), 16'd0);
    chk("midrst_sum_a", sum_a, 16'h0000);
    chk("midrst_sum_b", sum_b, 16'h0000);
    chk("midrst_data", out_data, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 16'(out_valid), 16'd0);
    chk("post_rst_ready", 16'(data_ready), 16'd1);
    run_pair(16'h4000, 16'h4000, 0);
    chk("post_rst_sum", out_data, 16'h4400);

    for (int i = 0; i < 40; i++) run_pair(rand_op(), rand_op(), int'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
